// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder sequencer that reuses one external combinational 2-bit adder
// slice, two bits per clock, LSB pair first. Define SERIAL_ADD_SUB_EN to add the
// 'sub' port (a - b via inverted B and carry-in of 1).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             add_cin,
    output logic             add_x1,
    output logic             add_y1,
    output logic             add_x2,
    output logic             add_y2,
    input  logic             add_s1,
    input  logic             add_s2,
    input  logic             add_cout
);

    localparam int unsigned     PAIRS    = WIDTH / 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_shift;
    logic [WIDTH-1:0]   r_b_shift;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic               w_carry_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               w_cout_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic [WIDTH-1:0]   w_sum_shift;

    // Operand B and initial carry as loaded on an accepted start
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub;
`else
    assign w_b_load   = b;
    assign w_cin_load = 1'b0;
`endif

    // New slice pair enters at the MSBs; after PAIRS shifts the sum is aligned
    assign w_sum_shift = (WIDTH'({add_s2, add_s1}) << (WIDTH - 2)) | (r_sum >> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a_shift;
        w_b_nxt     = r_b_shift;
        w_carry_nxt = r_carry;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = w_b_load;
                    w_carry_nxt = w_cin_load;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sum_nxt   = w_sum_shift;
                w_carry_nxt = add_cout;
                w_a_nxt     = r_a_shift >> 2;
                w_b_nxt     = r_b_shift >> 2;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_cout_nxt  = add_cout;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_shift <= '0;
            r_b_shift <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_a_shift <= w_a_nxt;
            r_b_shift <= w_b_nxt;
            r_carry   <= w_carry_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sum     <= w_sum_nxt;
            r_cout    <= w_cout_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign add_cin = r_carry;
    assign add_x1  = r_a_shift[0];
    assign add_y1  = r_b_shift[0];
    assign add_x2  = r_a_shift[1];
    assign add_y2  = r_b_shift[1];

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=2 with a scoreboard
// of expected {cout,sum}; subtract steps run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, start2;
    logic       sub8, sub2;
    logic [7:0] a8, b8, sum8;
    logic [1:0] a2, b2, sum2;
    logic       busy8, done8, cout8, cin8, x1_8, y1_8, x2_8, y2_8;
    logic       busy2, done2, cout2, cin2, x1_2, y1_2, x2_2, y2_2;
    logic [2:0] w_sl8, w_sl2;

    // External 2-bit ripple slices
    assign w_sl8 = {1'b0, x2_8, x1_8} + {1'b0, y2_8, y1_8} + {2'b00, cin8};
    assign w_sl2 = {1'b0, x2_2, x1_2} + {1'b0, y2_2, y1_2} + {2'b00, cin2};

    serial_add_ctrl #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .reset(rst), .start(start8),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub8),
`endif
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .add_cin(cin8), .add_x1(x1_8), .add_y1(y1_8), .add_x2(x2_8), .add_y2(y2_8),
        .add_s1(w_sl8[0]), .add_s2(w_sl8[1]), .add_cout(w_sl8[2])
    );

    serial_add_ctrl #(.WIDTH(2), .CNT_W(1)) dut2 (
        .clk(clk), .reset(rst), .start(start2),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub2),
`endif
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .add_cin(cin2), .add_x1(x1_2), .add_y1(y1_2), .add_x2(x2_2), .add_y2(y2_2),
        .add_s1(w_sl2[0]), .add_s2(w_sl2[1]), .add_cout(w_sl2[2])
    );

    int n_cmp = 0;
    int n_err = 0;
    int done8_cnt = 0, done2_cnt = 0;
    int exp_done8 = 0, exp_done2 = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each done pulse
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            logic [8:0] e8;
            done8_cnt++;
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL done8_unexpected observed=1 expected=0");
            end else begin
                e8 = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e8[7:0]));
                check("cout8", 32'(cout8), 32'(e8[8]));
            end
        end
        if (done2 === 1'b1) begin
            logic [2:0] e2;
            done2_cnt++;
            if (q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL done2_unexpected observed=1 expected=0");
            end else begin
                e2 = q2.pop_front();
                check("sum2", 32'(sum2), 32'(e2[1:0]));
                check("cout2", 32'(cout2), 32'(e2[2]));
            end
        end
    end

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub);
        int cyc;
        @(negedge clk);
        a8 = ta; b8 = tb; sub8 = tsub; start8 = 1'b1;
        q8.push_back(tsub ? ({1'b0, ta} + {1'b0, ~tb} + 9'd1) : ({1'b0, ta} + {1'b0, tb}));
        exp_done8++;
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_start", 32'(busy8), 32'd1);
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency8", 32'(cyc), 32'd5);
        @(negedge clk);
        check("done8_one_cycle", 32'(done8), 32'd0);
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb);
        int cyc;
        @(negedge clk);
        a2 = ta; b2 = tb; start2 = 1'b1;
        q2.push_back({1'b0, ta} + {1'b0, tb});
        exp_done2++;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency2", 32'(cyc), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b1; start8 = 1'b0; start2 = 1'b0; sub8 = 1'b0; sub2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_slice", 32'({cin8, x1_8, y1_8, x2_8, y2_8}), 32'd0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        check("sum8_hold", 32'(sum8), 32'h96);
        op8(8'h12, 8'h34, 1'b0);
        op8(8'h80, 8'h80, 1'b0);

        // Carry ripples through every pair
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        q8.push_back(9'h100);
        exp_done8++;
        @(negedge clk);
        start8 = 1'b0;
        check("cin_run1", 32'(cin8), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check("cin_run_later", 32'(cin8), 32'd1);
        end
        @(negedge clk);
        check("done8_ff01", 32'(done8), 32'd1);
        @(negedge clk);

        // start held through RUN and DONE must be ignored
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        q8.push_back(9'h003);
        exp_done8++;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22;
        cyc = 1;
        while (done8 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency8_busy_start", 32'(cyc), 32'd5);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy8_no_second_op", 32'(busy8), 32'd0);
        check("sum8_no_second_op", 32'(sum8), 32'h03);

        // Reset in the second RUN cycle
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_sum", 32'(sum8), 32'd0);
        check("midrst_cout", 32'(cout8), 32'd0);
        check("midrst_slice", 32'({cin8, x1_8, y1_8, x2_8, y2_8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op8(8'h0F, 8'h01, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        op8(8'h10, 8'h01, 1'b1);
        op8(8'h01, 8'h02, 1'b1);
        op8(8'h05, 8'h05, 1'b1);
        op8(8'h33, 8'h22, 1'b0);
`endif

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ab;
            ab = 4'(i);
            op2(ab[3:2], ab[1:0]);
        end

        repeat (4) @(negedge clk);
        check("done8_count", 32'(done8_cnt), 32'(exp_done8));
        check("done2_count", 32'(done2_cnt), 32'(exp_done2));
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
